// File: rtl/cache_pkg.sv
// Shared definitions for the I/D cache to memory arbiter: default widths,
// FSM state encoding and the port-select encoding used for round-robin.
package cache_pkg;

   localparam int ADDR_W_DEF = 28;
   localparam int DATA_W_DEF = 128;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GNT_I = 2'd1,
      ST_GNT_D = 2'd2
   } arb_state_t;

   typedef enum logic {
      SEL_I = 1'b0,
      SEL_D = 1'b1
   } port_sel_t;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Two-port (I-cache / D-cache) arbiter onto one shared block memory port.
// Round-robin on simultaneous requests; memory port muxed combinationally from state.
module cache_mem_arbiter
   import cache_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              proc_reset,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic              i_ready,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  conflict_cnt
);

   arb_state_t       r_state;
   arb_state_t       w_state_nxt;
   port_sel_t        r_last_gnt;
   port_sel_t        w_last_gnt_nxt;
   logic [CNT_W-1:0] r_conflict_cnt;
   logic             w_req_i;
   logic             w_req_d;
   logic             w_conflict;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign w_req_i = i_read | i_write;
   assign w_req_d = d_read | d_write;

   always_ff @(posedge clk or posedge proc_reset) begin
      if (proc_reset) begin
         r_state        <= ST_IDLE;
         r_last_gnt     <= SEL_I;
         r_conflict_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_last_gnt <= w_last_gnt_nxt;
         if (w_conflict)
            r_conflict_cnt <= sat_inc(r_conflict_cnt);
      end
   end

   // last_gnt only moves on a completed transfer, so a withdrawn request keeps its turn.
   always_comb begin
      w_state_nxt    = r_state;
      w_last_gnt_nxt = r_last_gnt;
      w_conflict     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req_i && w_req_d) begin
               w_conflict  = 1'b1;
               w_state_nxt = (r_last_gnt == SEL_I) ? ST_GNT_D : ST_GNT_I;
            end else if (w_req_i) begin
               w_state_nxt = ST_GNT_I;
            end else if (w_req_d) begin
               w_state_nxt = ST_GNT_D;
            end
         end
         ST_GNT_I: begin
            if (mem_ready) begin
               w_state_nxt    = ST_IDLE;
               w_last_gnt_nxt = SEL_I;
            end else if (!w_req_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_GNT_D: begin
            if (mem_ready) begin
               w_state_nxt    = ST_IDLE;
               w_last_gnt_nxt = SEL_D;
            end else if (!w_req_d) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      i_ready   = 1'b0;
      i_rdata   = '0;
      d_ready   = 1'b0;
      d_rdata   = '0;
      case (r_state)
         ST_GNT_I: begin
            mem_read  = i_read;
            mem_write = i_write;
            mem_addr  = i_addr;
            mem_wdata = i_wdata;
            i_ready   = mem_ready;
            i_rdata   = mem_rdata;
         end
         ST_GNT_D: begin
            mem_read  = d_read;
            mem_write = d_write;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            d_ready   = mem_ready;
            d_rdata   = mem_rdata;
         end
         default: ;
      endcase
   end

   assign busy         = (r_state != ST_IDLE);
   assign conflict_cnt = r_conflict_cnt;

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 28, block-address width.
REQ-002 SHALL have parameter DATA_W, default 128, block (4-word) data width.
REQ-003 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 proc_reset  input  1  asynchronous, active-high reset.
REQ-006 i_read, i_write  input  1 each  I-cache block read/write request (level, held until i_ready).
REQ-007 i_addr  input  ADDR_W  I-cache block address.
REQ-008 i_wdata  input  DATA_W  I-cache write-back data.
REQ-009 i_ready  output  1  I-cache completion pulse.
REQ-010 i_rdata  output  DATA_W  I-cache read data.
REQ-011 d_read, d_write, d_addr, d_wdata, d_ready, d_rdata  SHALL mirror REQ-006..010 for the D-cache.
REQ-012 mem_read, mem_write  output  1 each  shared memory request.
REQ-013 mem_addr  output  ADDR_W  shared memory block address.
REQ-014 mem_wdata  output  DATA_W  shared memory write data.
REQ-015 mem_rdata  input  DATA_W  memory read data, valid with mem_ready.
REQ-016 mem_ready  input  1  memory completion pulse.
REQ-017 busy  output  1  high while any grant is held.
REQ-018 conflict_cnt  output  CNT_W  count of cycles where both caches requested in IDLE.

Function
REQ-019 SHALL implement FSM with states IDLE, GNT_I, GNT_D (registered).
REQ-020 Request per port SHALL be req_x = x_read | x_write.
REQ-021 In IDLE: only req_i -> GNT_I; only req_d -> GNT_D; neither -> IDLE.
REQ-022 In IDLE with req_i and req_d both high SHALL grant the port not granted last (round-robin via registered last_gnt) and increment conflict_cnt.
REQ-023 Arbitration latency SHALL be exactly one cycle: request in IDLE at cycle N -> memory sees it at N+1.
REQ-024 In GNT_x: mem_read/mem_write/mem_addr/mem_wdata SHALL equal the granted port's inputs combinationally; all zero in IDLE.
REQ-025 In GNT_x: x_ready = mem_ready, x_rdata = mem_rdata; non-granted port ready = 0, rdata = 0.
REQ-026 In GNT_x with mem_ready = 1 SHALL return to IDLE next cycle and set last_gnt = x.
REQ-027 In GNT_x with req_x = 0 and mem_ready = 0 (requester withdrew) SHALL return to IDLE next cycle; last_gnt unchanged.
REQ-028 mem_ready while in IDLE SHALL be ignored (no ready to either port, no state change).
REQ-029 Back-to-back (write-back then refill) from same port SHALL re-arbitrate through IDLE; the other port, if waiting, wins (round-robin).
REQ-030 i_read and i_write both high SHALL forward both unchanged; resolution is memory's concern.
REQ-031 conflict_cnt SHALL saturate at all-ones, no wrap.
REQ-032 busy SHALL equal (state != IDLE).

Reset
REQ-033 On proc_reset: state = IDLE, last_gnt = I (so D wins first conflict), conflict_cnt = 0, all outputs 0, effective immediately (asynchronous), including mid-transaction.
REQ-034 After reset release, first arbitration SHALL occur on the first rising edge with proc_reset low.

Structure
REQ-035 State encoding (IDLE/GNT_I/GNT_D) and port-select encoding SHALL live in shared package cache_pkg alongside ADDR_W/DATA_W defaults.
REQ-036 SHALL be a single module; no sub-module; output mux is combinational from registered state.

Verification
REQ-037 Only d_read, d_addr=0x0000010 at cycle 0 -> GNT_D at cycle 1, mem_read=1, mem_addr=0x0000010; mem_ready with mem_rdata=0xA5..A5 at cycle 4 -> d_ready=1, d_rdata=0xA5..A5, IDLE at cycle 5.
REQ-038 i_read and d_write simultaneous after reset -> D granted first, conflict_cnt=1; after D's mem_ready, I granted next arbitration, last_gnt=I->D->I sequence verified.
REQ-039 D write-back then D refill while i_read held -> order D-write, I-read, D-read on memory port; i_ready never high during D grants.
REQ-040 GNT_I then i_read dropped before mem_ready -> IDLE next cycle, mem_read=0, late mem_ready in IDLE produces no ready.
REQ-041 proc_reset asserted mid GNT_D -> mem_read/mem_write/d_ready drop same cycle, state IDLE, conflict_cnt=0.
REQ-042 Force 2^CNT_W+3 conflict cycles -> conflict_cnt holds 0xFFFF.
